// File: rtl/banked_byte_ram_pkg.sv
// Shared types and derived sizes for the banked byte-lane RAM.
package banked_byte_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic int lanes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int bank_depth(input int bank_addr_width);
        return 1 << bank_addr_width;
    endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// One bank: LANES byte-wide RAMs, per-lane write enable, 1-cycle read.
module banked_ram_bank
    import banked_byte_ram_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int BANK_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic [BANK_ADDR_WIDTH-1:0] addr,
    input  logic [LANES-1:0]           we,
    input  logic [LANES*8-1:0]         din,
    output logic [LANES*8-1:0]         dout
);

    localparam int DEPTH = bank_depth(BANK_ADDR_WIDTH);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[addr] <= din[l*8 +: 8];
            end
            rd_q <= mem[addr];
        end

        assign dout[l*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/banked_byte_ram.sv
// Byte-lane single-port RAM of NUM_BANKS power-of-two banks with
// request handshake, range check, optional output register and zero-fill.
module banked_byte_ram
    import banked_byte_ram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int NUM_BANKS       = 3,
    parameter int OUTPUT_REG      = 0,
    parameter int INIT_ON_RESET   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] write_en,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    addr_err,
    output logic                    init_done
);

    localparam int LANES = lanes(DATA_WIDTH);
    localparam int BW    = ADDR_WIDTH - BANK_ADDR_WIDTH;
    localparam logic [BW:0] NB = (BW + 1)'(NUM_BANKS);
    localparam state_e RST_ST = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_e                     state_q, state_d;
    logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                       run;

    logic [BW-1:0]              bank;
    logic [BANK_ADDR_WIDTH-1:0] offset;
    logic                       in_range;
    logic                       is_rd;
    logic                       accept;

    logic [BANK_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]      mem_din;
    logic [LANES-1:0]           mem_we [NUM_BANKS];
    logic [DATA_WIDTH-1:0]      bank_dout [NUM_BANKS];
    logic [DATA_WIDTH-1:0]      rdata;

    logic          rd1_q, rd1_d;
    logic          wr_err1_q, wr_err1_d;
    logic          oor1_q, oor1_d;
    logic [BW-1:0] bsel1_q, bsel1_d;

    // Outputs are forced low while reset is held so nothing leaks out.
    assign run       = (state_q == ST_RUN);
    assign req_ready = run & ~reset;
    assign init_done = run & ~reset;

    assign bank     = addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    assign offset   = addr[BANK_ADDR_WIDTH-1:0];
    assign in_range = {1'b0, bank} < NB;
    assign is_rd    = ~|write_en;
    assign accept   = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_ST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // During the sweep every bank writes zero to all lanes at cnt_q.
    always_comb begin
        mem_addr = run ? offset : cnt_q;
        mem_din  = run ? din : '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            mem_we[b] = '0;
            if (!run) begin
                mem_we[b] = '1;
            end else if (accept && in_range && bank == BW'(b)) begin
                mem_we[b] = write_en;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        banked_ram_bank #(
            .LANES          (LANES),
            .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH)
        ) u_bank (
            .clk (clk),
            .addr(mem_addr),
            .we  (mem_we[b]),
            .din (mem_din),
            .dout(bank_dout[b])
        );
    end

    always_comb begin
        rd1_d     = accept & is_rd;
        wr_err1_d = accept & ~is_rd & ~in_range;
        oor1_d    = ~in_range;
        bsel1_d   = bank;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_q     <= 1'b0;
            wr_err1_q <= 1'b0;
        end else begin
            rd1_q     <= rd1_d;
            wr_err1_q <= wr_err1_d;
        end
    end

    always_ff @(posedge clk) begin
        oor1_q  <= oor1_d;
        bsel1_q <= bsel1_d;
    end

    // An out-of-range bank index matches no bank, so its data reads as 0.
    always_comb begin
        rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bsel1_q == BW'(b)) begin
                rdata = bank_dout[b];
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic                  rd2_q, rd2_d;
        logic                  err2_q, err2_d;
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            rd2_d  = rd1_q;
            err2_d = rd1_q & oor1_q;
            dout_d = rd1_q ? rdata : dout_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd2_q  <= 1'b0;
                err2_q <= 1'b0;
                dout_q <= '0;
            end else begin
                rd2_q  <= rd2_d;
                err2_q <= err2_d;
                dout_q <= dout_d;
            end
        end

        assign rd_valid = rd2_q & ~reset;
        assign addr_err = (wr_err1_q | err2_q) & ~reset;
        assign dout     = dout_q;
    end else begin : g_comb
        assign rd_valid = rd1_q & ~reset;
        assign addr_err = (wr_err1_q | (rd1_q & oor1_q)) & ~reset;
        assign dout     = rdata;
    end

endmodule

// File: tb/tb_banked_byte_ram.sv
// Randomised bench for banked_byte_ram: two instances (combinational
// output with zero-fill, registered output without) against one model.
module tb_banked_byte_ram;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BAW = 4;
    localparam int NBK = 3;
    localparam int TOP = NBK * (1 << BAW);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [3:0]    write_en = '0;

    logic          r1, v1, e1, i1;
    logic [DW-1:0] d1;
    logic          r2, v2, e2, i2;
    logic [DW-1:0] d2;

    int checks = 0;
    int errors = 0;

    banked_byte_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(BAW),
        .NUM_BANKS(NBK), .OUTPUT_REG(0), .INIT_ON_RESET(1)
    ) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1),
        .addr(addr), .din(din), .write_en(write_en), .rd_valid(v1),
        .dout(d1), .addr_err(e1), .init_done(i1)
    );

    banked_byte_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(BAW),
        .NUM_BANKS(NBK), .OUTPUT_REG(1), .INIT_ON_RESET(0)
    ) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r2),
        .addr(addr), .din(din), .write_en(write_en), .rd_valid(v2),
        .dout(d2), .addr_err(e2), .init_done(i2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    // Model: word memory per instance, response slots indexed by cycle.
    logic [DW-1:0] mem [2][64];
    int unsigned   cyc = 0;
    bit            started = 0;
    int            init_left = 0;
    bit            s_rv [2][8];
    bit            s_err [2][8];
    logic [DW-1:0] s_d [2][8];
    logic [DW-1:0] last2 = '0;

    function automatic bit ready_of(input int k);
        if (k == 0) return !reset && init_left == 0;
        return !reset;
    endfunction

    always @(posedge clk) begin
        bit rdy [2];
        rdy[0] = ready_of(0);
        rdy[1] = ready_of(1);
        cyc++;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 8; s++) begin
                    s_rv[k][s] = 0;
                    s_err[k][s] = 0;
                end
            end
            for (int a = 0; a < 64; a++) mem[0][a] = '0;
            last2 = '0;
            init_left = 16;
            started = 1;
        end else begin
            if (init_left > 0) init_left--;
            for (int k = 0; k < 2; k++) begin
                if (req_valid && rdy[k]) begin
                    bit inr;
                    int s;
                    inr = int'(addr) < TOP;
                    s = int'((cyc + unsigned'(k)) % 8);
                    if (write_en != 0) begin
                        if (inr) begin
                            for (int l = 0; l < 4; l++)
                                if (write_en[l])
                                    mem[k][addr][l*8 +: 8] = din[l*8 +: 8];
                        end else begin
                            s_err[k][cyc % 8] = 1;
                        end
                    end else begin
                        s_rv[k][s] = 1;
                        if (!inr) s_err[k][s] = 1;
                        s_d[k][s] = inr ? mem[k][addr] : '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int s;
            bit erv [2];
            bit eer [2];
            s = int'(cyc % 8);
            for (int k = 0; k < 2; k++) begin
                erv[k] = !reset && s_rv[k][s];
                eer[k] = !reset && s_err[k][s];
            end
            if (s_rv[1][s]) last2 = s_d[1][s];
            chk("ready1", {31'd0, r1}, {31'd0, ready_of(0)});
            chk("done1", {31'd0, i1}, {31'd0, ready_of(0)});
            chk("rdv1", {31'd0, v1}, {31'd0, erv[0]});
            chk("err1", {31'd0, e1}, {31'd0, eer[0]});
            if (erv[0] && !$isunknown(s_d[0][s])) chk("dout1", d1, s_d[0][s]);
            chk("ready2", {31'd0, r2}, {31'd0, ready_of(1)});
            chk("done2", {31'd0, i2}, {31'd0, ready_of(1)});
            chk("rdv2", {31'd0, v2}, {31'd0, erv[1]});
            chk("err2", {31'd0, e2}, {31'd0, eer[1]});
            if (!$isunknown(last2)) chk("dout2", d2, last2);
            for (int k = 0; k < 2; k++) begin
                s_rv[k][s] = 0;
                s_err[k][s] = 0;
            end
        end
    end

    task automatic put(input bit v, input int a, input logic [DW-1:0] d,
                       input logic [3:0] we);
        req_valid = v;
        addr = AW'(a);
        din = d;
        write_en = we;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        write_en = '0;
    endtask

    task automatic rd_lit(input string name, input int a,
                          input logic [DW-1:0] exp, input bit chk2);
        put(1, a, '0, 4'h0);
        idle();
        #1;
        chk({name, "_v1"}, {31'd0, v1}, 32'd1);
        chk({name, "_d1"}, d1, exp);
        @(posedge clk);
        #3;
        if (chk2) chk({name, "_d2"}, d2, exp);
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        @(negedge clk);
        chk({name, "_noinit_ready"}, {31'd0, r2}, 32'd1);
        chk({name, "_noinit_done"}, {31'd0, i2}, 32'd1);
        while (r1 == 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_cycles"}, n, 16);
        chk({name, "_done"}, {31'd0, i1}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        count_init("init");

        rd_lit("zero0", 0, 32'h0, 0);
        rd_lit("zero17", 17, 32'h0, 0);
        rd_lit("zero47", 47, 32'h0, 0);

        for (int a = 0; a < TOP; a++) put(1, a, '0, 4'hf);
        idle();

        put(1, 5, 32'hAABBCCDD, 4'b1111);
        put(1, 5, 32'h11223344, 4'b0101);
        rd_lit("lanes", 5, 32'hAA22CC44, 1);

        put(1, 3, 32'h1, 4'hf);
        put(1, 19, 32'h2, 4'hf);
        put(1, 35, 32'h3, 4'hf);
        put(1, 3, '0, 4'h0);
        put(1, 19, '0, 4'h0);
        put(1, 35, '0, 4'h0);
        idle();
        #1;
        chk("xbank_d1", d1, 32'h3);
        @(posedge clk);
        #3;
        chk("xbank_d2", d2, 32'h3);

        put(1, 48, 32'hFFFFFFFF, 4'hf);
        idle();
        #1;
        chk("oor_wr_err", {31'd0, e1}, 32'd1);
        chk("oor_wr_rv", {31'd0, v1}, 32'd0);
        rd_lit("oor_keep0", 0, 32'h0, 1);
        put(1, 63, '0, 4'h0);
        idle();
        #1;
        chk("oor_rd_v1", {31'd0, v1}, 32'd1);
        chk("oor_rd_e1", {31'd0, e1}, 32'd1);
        chk("oor_rd_d1", d1, 32'h0);
        @(posedge clk);
        #3;
        chk("oor_rd_e2", {31'd0, e2}, 32'd1);
        chk("oor_rd_d2", d2, 32'h0);

        put(1, 3, '0, 4'h0);
        idle();
        reset = 1'b1;
        #1;
        chk("mid_rv1a", {31'd0, v1}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rv1b", {31'd0, v1}, 32'd0);
        chk("mid_rv2", {31'd0, v2}, 32'd0);
        chk("mid_ready1", {31'd0, r1}, 32'd0);
        count_init("reinit");

        for (int i = 0; i < 400; i++) begin
            bit v;
            logic [3:0] we;
            if (i == 200) reset = 1'b1;
            if (i == 202) reset = 1'b0;
            v = $urandom_range(0, 9) < 7;
            we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            put(v, int'($urandom_range(0, 63)), $urandom, we);
        end
        idle();
        repeat (4) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
